// File: rtl/alu_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_ctrl
// Purpose  : Execute-stage ALU control. Provides the combinational op_sel
//            decode for base-ISA ALU ops, plus a multi-cycle RV32M/RV64M unit
//            (shift-add multiplier + restoring divider) sequenced by an FSM.
// Ports    : clk, reset_n            - clock, async active-low reset
//            i_in_valid             - instruction in execute is valid
//            i_opcode_upper/funct3/funct7 - instruction fields
//            i_rs1_data/i_rs2_data  - operands
//            i_flush                - kill any in-flight M op
//            o_op_sel               - ALU op select (combinational)
//            o_is_muldiv            - M-extension instruction (combinational)
//            o_stall                - hold the pipeline while an M op runs
//            o_out_valid/o_result   - registered one-cycle result strobe/data
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_in_valid,
  input  logic [4:0]      i_opcode_upper,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic [3:0]      o_op_sel,
  output logic            o_is_muldiv,
  output logic            o_stall,
  output logic            o_out_valid,
  output logic [XLEN-1:0] o_result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_OPIMM = 5'b00100;
  localparam logic [4:0] OPC_OP    = 5'b01100;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic [1:0]        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_f3;       // funct3[1:0] of the accepted op
  logic              r_neg_p;    // negate product / quotient at the end
  logic              r_neg_r;    // negate remainder at the end
  logic [XLEN-1:0]   r_a;        // multiplicand or divisor magnitude
  logic [XLEN-1:0]   r_hi;       // product high half or partial remainder
  logic [XLEN-1:0]   r_lo;       // multiplier/product low or dividend/quotient
  logic              r_out_valid;
  logic [XLEN-1:0]   r_result;

  // ---------------------------------------------------------------- decode
  logic w_is_muldiv;
  assign w_is_muldiv = (i_opcode_upper == OPC_OP) && (i_funct7 == 7'b0000001);

  always_comb begin
    o_op_sel = 4'b0000;
    case (i_opcode_upper)
      OPC_LUI:   o_op_sel = 4'b1111;
      OPC_OPIMM: o_op_sel = (i_funct3 == 3'b101) ? {i_funct7[5], i_funct3}
                                                 : {1'b0, i_funct3};
      OPC_OP:    o_op_sel = w_is_muldiv ? 4'b0000 : {i_funct7[5], i_funct3};
      default:   o_op_sel = 4'b0000;
    endcase
  end

  // ---------------------------------------------------- operand preparation
  logic w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0] w_rs1_mag, w_rs2_mag, w_special_res;

  assign w_accept = (r_state == S_IDLE) & i_in_valid & w_is_muldiv & ~i_flush & ~r_out_valid;

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
  // MUL is handled unsigned: the low half of the product is sign-agnostic.
  assign w_a_signed = (i_funct3 == 3'b001) | (i_funct3 == 3'b010) |
                      (i_funct3 == 3'b100) | (i_funct3 == 3'b110);
  assign w_b_signed = (i_funct3 == 3'b001) | (i_funct3 == 3'b100) | (i_funct3 == 3'b110);
  assign w_a_neg    = w_a_signed & i_rs1_data[XLEN-1];
  assign w_b_neg    = w_b_signed & i_rs2_data[XLEN-1];
  assign w_rs1_mag  = w_a_neg ? -i_rs1_data : i_rs1_data;
  assign w_rs2_mag  = w_b_neg ? -i_rs2_data : i_rs2_data;

  // Divide corner cases resolve in one cycle without iterating.
  assign w_div_zero = (i_rs2_data == '0);
  assign w_div_ovf  = ~i_funct3[0] & (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (&i_rs2_data);
  assign w_special  = i_funct3[2] & (w_div_zero | w_div_ovf);
  assign w_special_res = w_div_zero ? (i_funct3[1] ? i_rs1_data : '1)
                                    : (i_funct3[1] ? '0 : i_rs1_data);

  // ------------------------------------------------------- iteration logic
  // Multiply: add multiplicand into the high half when the multiplier LSB is
  // set, then shift the whole product right by one.
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN-1:0] w_mul_hi, w_mul_lo;
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
  assign w_mul_hi  = w_mul_sum[XLEN:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[XLEN-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits; the quotient bit enters at the LSB.
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_rem_sub, w_div_hi, w_div_lo;
  logic            w_ge;
  assign w_rem_sh  = {r_hi, r_lo[XLEN-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_a});
  assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_a;
  assign w_div_hi  = w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
  assign w_div_lo  = {r_lo[XLEN-2:0], w_ge};

  logic [XLEN-1:0] w_iter_hi, w_iter_lo;
  assign w_iter_hi = (r_state == S_MUL) ? w_mul_hi : w_div_hi;
  assign w_iter_lo = (r_state == S_MUL) ? w_mul_lo : w_div_lo;

  // Sign correction applied to the values produced by the final iteration.
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_mul_res, w_quo, w_rem, w_div_res, w_final;
  assign w_prod    = {w_iter_hi, w_iter_lo};
  assign w_prod_s  = r_neg_p ? -w_prod : w_prod;
  assign w_mul_res = (r_f3 == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
  assign w_quo     = r_neg_p ? -w_iter_lo : w_iter_lo;
  assign w_rem     = r_neg_r ? -w_iter_hi : w_iter_hi;
  assign w_div_res = r_f3[1] ? w_rem : w_quo;
  assign w_final   = (r_state == S_MUL) ? w_mul_res : w_div_res;

  // ----------------------------------------------------------- FSM: state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ------------------------------------------------------ FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : (i_funct3[2] ? S_DIV : S_MUL);
      S_MUL,
      S_DIV:   if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) w_state_nxt = S_IDLE;
  end

  // ---------------------------------------------------------- FSM: outputs
  logic w_iter, w_finish, w_ov_nxt;
  always_comb begin
    w_iter   = (r_state == S_MUL) | (r_state == S_DIV);
    w_finish = w_iter & (r_cnt == CNT_LAST);
    // flush on the finishing edge suppresses the strobe and the result update
    w_ov_nxt = ((w_accept & w_special) | w_finish) & ~i_flush;
    o_stall  = i_in_valid & w_is_muldiv & ~r_out_valid & ~i_flush;
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_f3        <= '0;
      r_neg_p     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_a         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      r_out_valid <= w_ov_nxt;
      if (w_ov_nxt) r_result <= w_accept ? w_special_res : w_final;

      if (i_flush) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_f3    <= i_funct3[1:0];
        r_neg_p <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
        r_hi    <= '0;
        r_a     <= i_funct3[2] ? w_rs2_mag : w_rs1_mag;
        r_lo    <= i_funct3[2] ? w_rs1_mag : w_rs2_mag;
      end else if (w_iter) begin
        r_hi  <= w_iter_hi;
        r_lo  <= w_iter_lo;
        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_is_muldiv = w_is_muldiv;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_ctrl
// Purpose  : Directed self-checking bench for alu_muldiv_ctrl (XLEN=32).
//            Expected M-op results come from a behavioural reference model
//            and flow through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic [3:0]  op_sel;
  logic        is_muldiv, stall, out_valid;
  logic [31:0] result;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  alu_muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_in_valid     (in_valid),
    .i_opcode_upper (opcode),
    .i_funct3       (funct3),
    .i_funct7       (funct7),
    .i_rs1_data     (rs1),
    .i_rs2_data     (rs2),
    .i_flush        (flush),
    .o_op_sel       (op_sel),
    .o_is_muldiv    (is_muldiv),
    .o_stall        (stall),
    .o_out_valid    (out_valid),
    .o_result       (result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model using native wide/signed arithmetic.
  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] ea, eb;
    logic signed [65:0] p;
    logic [31:0] q, r;
    int sa, sb;
    if (!f3[2]) begin
      ea = (f3 == 3'b011) ? $signed({1'b0, a}) : $signed({a[31], a});
      eb = (f3 == 3'b001) ? $signed({b[31], b}) : $signed({1'b0, b});
      p  = ea * eb;
      return (f3 == 3'b000) ? p[31:0] : p[63:32];
    end
    sa = a; sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0;
    end else if (!f3[0]) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Starts at the beginning of a cycle (just after a rising edge); that cycle
  // is the acceptance cycle 0. Returns at the start of the following cycle.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int lat;
    bit seen;
    sb_q.push_back(ref_m(f3, a, b));
    lat = ref_lat(f3, a, b);
    opcode = 5'b01100; funct7 = 7'b0000001; funct3 = f3; rs1 = a; rs2 = b; in_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c <= 40 && !seen; c++) begin
      @(negedge clk);
      chk({tag, " stall"}, 64'(stall), 64'(c < lat));
      if (out_valid) begin
        seen = 1'b1;
        chk({tag, " latency"}, 64'(c), 64'(lat));
        chk({tag, " result"}, 64'(result), 64'(sb_q.pop_front()));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({tag, " completed"}, 64'(seen), 64'd1);
  endtask

  task automatic set_dec(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op; funct3 = f3; funct7 = f7;
    #1;
  endtask

  initial begin
    bit saw_ov;
    reset_n = 1'b0; in_valid = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    rs1 = '0; rs2 = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);

    // Decode sweep (in_valid low, nothing is accepted)
    set_dec(5'b01101, 3'b000, 7'b0000000); chk("dec LUI", 64'(op_sel), 64'hF);
    set_dec(5'b00100, 3'b101, 7'b0100000); chk("dec SRAI", 64'(op_sel), 64'hD);
    set_dec(5'b00100, 3'b000, 7'b0100000); chk("dec ADDI", 64'(op_sel), 64'h0);
    set_dec(5'b01100, 3'b000, 7'b0100000); chk("dec SUB", 64'(op_sel), 64'h8);
    chk("dec SUB is_muldiv", 64'(is_muldiv), 64'd0);
    set_dec(5'b01100, 3'b000, 7'b0000001); chk("dec MUL", 64'(op_sel), 64'h0);
    chk("dec MUL is_muldiv", 64'(is_muldiv), 64'd1);
    @(posedge clk); #1;

    // Multiplies
    run_op("MUL",    3'b000, 32'd7,         32'hFFFF_FFFD);
    run_op("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000);
    run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'd2);
    run_op("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    // Divides
    run_op("DIV",    3'b100, 32'hFFFF_FFF9, 32'd2);
    run_op("REM",    3'b110, 32'hFFFF_FFF9, 32'd2);
    run_op("DIVU",   3'b101, 32'd100,       32'd7);
    run_op("REMU",   3'b111, 32'd100,       32'd7);
    // Divide corner cases
    run_op("DIVU0",  3'b101, 32'd5,         32'd0);
    run_op("REM0",   3'b110, 32'd5,         32'd0);
    run_op("DIVOVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("REMOVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in cycle 10 of a DIV
    opcode = 5'b01100; funct7 = 7'b0000001; funct3 = 3'b100;
    rs1 = 32'd1000; rs2 = 32'd3; in_valid = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    saw_ov = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw_ov = 1'b1;
    end
    chk("flush no out_valid", 64'(saw_ov), 64'd0);
    @(posedge clk); #1;
    run_op("MUL after flush", 3'b000, 32'd3, 32'd4);

    // Asynchronous reset mid-MUL, between clock edges
    opcode = 5'b01100; funct7 = 7'b0000001; funct3 = 3'b000;
    rs1 = 32'd5; rs2 = 32'd6; in_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst result", 64'(result), 64'd0);
    in_valid = 1'b0;
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back ops; each must be accepted in the cycle right after the
    // previous strobe, which the latency check enforces.
    run_op("B2B MULHU", 3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("B2B DIV",   3'b100, 32'h8765_4321, 32'h0000_1234);
    run_op("B2B REMU",  3'b111, 32'hDEAD_BEEF, 32'h0000_0101);

    chk("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
